// File: rtl/rs232c_tx_arbiter.sv
// rs232c_tx_arbiter: round-robin packet arbiter feeding one UART transmitter;
// a granted requester keeps the transmitter until its LAST byte or a hold timeout.
module rs232c_tx_arbiter #(
  parameter logic [15:0] P_HOLD_TIMEOUT = 16'd40000
) (
  input  logic       CLK,
  input  logic       RESETB,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic [7:0] DATA0,
  input  logic [7:0] DATA1,
  input  logic       LAST0,
  input  logic       LAST1,
  output logic       ACK0,
  output logic       ACK1,
  output logic [7:0] TX_DATA,
  output logic       TX_DATA_EN,
  input  logic       TX_BUSY,
  output logic [1:0] GNT,
  output logic       TIMEOUT_ERR
);
  typedef enum logic [1:0] {IDLE, SENT, HOLD} state_t;
  state_t      state_q, state_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_en_q, tx_en_d, tout_q, tout_d, rr_q, rr_d, last_q, last_d, ready_q;
  logic [1:0]  ack_q, ack_d, gnt_q, gnt_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  req;
  logic        owner, win, issue, sent_done, hold_wait, hold_to, rel;
  assign req       = {REQ1, REQ0};
  assign owner     = gnt_q[1];
  assign win       = (state_q == HOLD) ? owner : (&req ? rr_q : REQ1);
  // ready_q delays the first issue until the second edge after reset release
  assign issue     = (state_q == IDLE && ready_q && !TX_BUSY && |req) ||
                     (state_q == HOLD && req[owner]);
  assign sent_done = state_q == SENT && !TX_BUSY;
  assign hold_wait = state_q == HOLD && !req[owner];
  assign hold_to   = hold_wait && cnt_q == P_HOLD_TIMEOUT - 16'd1;
  assign rel       = (sent_done && last_q) || hold_to;
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q   <= IDLE;
      tx_data_q <= 8'h00;
      tx_en_q   <= 1'b0;
      ack_q     <= 2'b00;
      gnt_q     <= 2'b00;
      tout_q    <= 1'b0;
      rr_q      <= 1'b0;
      last_q    <= 1'b0;
      cnt_q     <= 16'd0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      ack_q     <= ack_d;
      gnt_q     <= gnt_d;
      tout_q    <= tout_d;
      rr_q      <= rr_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      ready_q   <= 1'b1;
    end
  end
  always_comb begin
    state_d = issue ? SENT : sent_done ? (last_q ? IDLE : HOLD) : hold_to ? IDLE : state_q;
  end
  always_comb begin
    tx_data_d = issue ? (win ? DATA1 : DATA0) : tx_data_q;
    tx_en_d   = issue;
    ack_d     = issue ? (win ? 2'b10 : 2'b01) : 2'b00;
    gnt_d     = issue ? (win ? 2'b10 : 2'b01) : rel ? 2'b00 : gnt_q;
    rr_d      = rel ? ~owner : rr_q;
    last_d    = issue ? (win ? LAST1 : LAST0) : last_q;
    cnt_d     = sent_done ? 16'd0 : hold_wait ? cnt_q + 16'd1 : cnt_q;
    tout_d    = hold_to;
  end
  assign TX_DATA     = tx_data_q;
  assign TX_DATA_EN  = tx_en_q;
  assign ACK0        = ack_q[0];
  assign ACK1        = ack_q[1];
  assign GNT         = gnt_q;
  assign TIMEOUT_ERR = tout_q;
endmodule

// File: tb/tb_rs232c_tx_arbiter.sv
// tb_rs232c_tx_arbiter: directed checks of arbitration order, packet locking,
// hold timeout, reset abandonment and TX_BUSY gating.
module tb_rs232c_tx_arbiter;
  logic       CLK = 1'b0, RESETB = 1'b0, ext_busy = 1'b0;
  logic       ACK0, ACK1, TX_DATA_EN, TIMEOUT_ERR, REQ0, REQ1, LAST0, LAST1, TX_BUSY;
  logic [7:0] TX_DATA, DATA0, DATA1;
  logic [1:0] GNT;
  logic [8:0] m0 [32];
  logic [8:0] m1 [32];
  int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0, bcnt = 0;
  int n_cmp = 0, n_err = 0, nlog = 0, cyc = 0, ack0_cnt = 0, ack1_cnt = 0, tout_cnt = 0;
  int en_cyc = 0, tout_cyc = 0, t0 = 0;
  logic [7:0] log_q [64];

  always #5 CLK = ~CLK;

  assign REQ0 = rd0 != wr0;
  assign REQ1 = rd1 != wr1;
  assign DATA0 = m0[rd0[4:0]][7:0];
  assign LAST0 = m0[rd0[4:0]][8];
  assign DATA1 = m1[rd1[4:0]][7:0];
  assign LAST1 = m1[rd1[4:0]][8];
  assign TX_BUSY = ext_busy | TX_DATA_EN | (bcnt != 0);

  rs232c_tx_arbiter #(.P_HOLD_TIMEOUT(16'd8)) dut (
    .CLK(CLK), .RESETB(RESETB), .REQ0(REQ0), .REQ1(REQ1), .DATA0(DATA0), .DATA1(DATA1),
    .LAST0(LAST0), .LAST1(LAST1), .ACK0(ACK0), .ACK1(ACK1), .TX_DATA(TX_DATA),
    .TX_DATA_EN(TX_DATA_EN), .TX_BUSY(TX_BUSY), .GNT(GNT), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push0(input logic last, input logic [7:0] d);
    m0[wr0[4:0]] = {last, d};
    wr0++;
  endtask

  task automatic push1(input logic last, input logic [7:0] d);
    m1[wr1[4:0]] = {last, d};
    wr1++;
  endtask

  // One cycle: sample at the falling edge, then act as requesters and transmitter.
  task automatic tick();
    @(negedge CLK);
    cyc++;
    if (TX_DATA_EN) begin
      log_q[nlog[5:0]] = TX_DATA;
      nlog++;
      en_cyc = cyc;
    end
    if (TIMEOUT_ERR) begin
      tout_cnt++;
      tout_cyc = cyc;
    end
    if (ACK0) begin
      rd0++;
      ack0_cnt++;
    end
    if (ACK1) begin
      rd1++;
      ack1_cnt++;
    end
    bcnt = TX_DATA_EN ? 3 : (bcnt > 0 ? bcnt - 1 : 0);
  endtask

  task automatic wait_log(input int n, input string tag);
    for (int i = 0; i < 80 && nlog < n; i++) tick();
    chk(tag, 32'(nlog >= n), 32'd1);
  endtask

  task automatic wait_unlock(input string tag);
    for (int i = 0; i < 40 && GNT != 2'b00; i++) tick();
    chk(tag, 32'(GNT), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESETB = 1'b0;
    rd0 = wr0;
    rd1 = wr1;
    bcnt = 0;
    tick();
    RESETB = 1'b1;
    tick();
    tick();
    nlog = 0;
  endtask

  initial begin
    // reset values and first-issue delay after release
    push0(1'b1, 8'h41);
    tick();
    tick();
    chk("rst_tx_data", 32'(TX_DATA), 32'h00);
    chk("rst_tx_en", 32'(TX_DATA_EN), 32'd0);
    chk("rst_ack", 32'({ACK1, ACK0}), 32'd0);
    chk("rst_gnt", 32'(GNT), 32'd0);
    chk("rst_tout", 32'(TIMEOUT_ERR), 32'd0);
    RESETB = 1'b1;
    tick();
    chk("no_issue_first_edge", 32'(TX_DATA_EN), 32'd0);
    tick();
    chk("single_en", 32'(TX_DATA_EN), 32'd1);
    chk("single_data", 32'(TX_DATA), 32'h41);
    chk("single_ack", 32'({ACK1, ACK0}), 32'b01);
    chk("single_gnt", 32'(GNT), 32'b01);
    tick();
    chk("single_en_pulse", 32'(TX_DATA_EN), 32'd0);
    chk("single_ack_pulse", 32'(ACK0), 32'd0);
    chk("single_gnt_busy", 32'(GNT), 32'b01);
    wait_unlock("single_unlock");
    chk("single_ack_count", 32'(ack0_cnt), 32'd1);
    chk("single_byte_count", 32'(nlog), 32'd1);

    // round robin from reset: both pending, two single-byte packets each
    do_reset();
    push0(1'b1, 8'hA0);
    push0(1'b1, 8'hA2);
    push1(1'b1, 8'hB1);
    push1(1'b1, 8'hB3);
    wait_log(4, "rr_done");
    chk("rr_0", 32'(log_q[0]), 32'hA0);
    chk("rr_1", 32'(log_q[1]), 32'hB1);
    chk("rr_2", 32'(log_q[2]), 32'hA2);
    chk("rr_3", 32'(log_q[3]), 32'hB3);
    wait_unlock("rr_unlock");

    // 3-byte packet from requester 0 is not interleaved with pending requester 1
    nlog = 0;
    push1(1'b1, 8'hC4);
    push0(1'b0, 8'h01);
    push0(1'b0, 8'h02);
    push0(1'b1, 8'h03);
    wait_log(3, "pkt_three");
    chk("pkt_no_ack1_early", 32'(REQ1), 32'd1);
    wait_log(4, "pkt_done");
    chk("pkt_0", 32'(log_q[0]), 32'h01);
    chk("pkt_1", 32'(log_q[1]), 32'h02);
    chk("pkt_2", 32'(log_q[2]), 32'h03);
    chk("pkt_3", 32'(log_q[3]), 32'hC4);
    wait_unlock("pkt_unlock");

    // hold timeout: non-LAST byte then silence while requester 1 waits
    nlog = 0;
    tout_cnt = 0;
    push0(1'b0, 8'h55);
    push1(1'b1, 8'h66);
    wait_log(1, "to_first");
    t0 = en_cyc;
    chk("to_first_data", 32'(log_q[0]), 32'h55);
    for (int i = 0; i < 11; i++) tick();
    chk("to_not_yet", 32'(TIMEOUT_ERR), 32'd0);
    chk("to_locked", 32'(GNT), 32'b01);
    tick();
    chk("to_pulse", 32'(TIMEOUT_ERR), 32'd1);
    chk("to_gnt_clear", 32'(GNT), 32'd0);
    chk("to_delay", 32'(tout_cyc - t0), 32'd12);
    wait_log(2, "to_next");
    chk("to_served_req1", 32'(log_q[1]), 32'h66);
    chk("to_served_latency", 32'(en_cyc - t0), 32'd13);
    chk("to_once", 32'(tout_cnt), 32'd1);
    wait_unlock("to_unlock");

    // reset while SENT abandons the byte and issues nothing afterwards
    nlog = 0;
    push0(1'b1, 8'h77);
    wait_log(1, "rs_issue");
    tick();
    RESETB = 1'b0;
    #1;
    chk("rs_gnt", 32'(GNT), 32'd0);
    chk("rs_en", 32'(TX_DATA_EN), 32'd0);
    chk("rs_data", 32'(TX_DATA), 32'h00);
    chk("rs_ack", 32'({ACK1, ACK0}), 32'd0);
    rd0 = wr0;
    rd1 = wr1;
    bcnt = 0;
    tick();
    RESETB = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("rs_quiet", 32'(nlog), 32'd1);

    // external TX_BUSY blocks the IDLE issue until it drops
    ack1_cnt = 0;
    ext_busy = 1'b1;
    push1(1'b1, 8'h88);
    for (int i = 0; i < 5; i++) tick();
    chk("busy_no_en", 32'(nlog), 32'd1);
    chk("busy_no_ack", 32'(ack1_cnt), 32'd0);
    ext_busy = 1'b0;
    tick();
    chk("busy_issue_en", 32'(TX_DATA_EN), 32'd1);
    chk("busy_issue_data", 32'(TX_DATA), 32'h88);
    chk("busy_issue_ack", 32'({ACK1, ACK0}), 32'b10);
    chk("busy_issue_gnt", 32'(GNT), 32'b10);
    wait_unlock("busy_unlock");

    // owner request at the timeout count wins over the timeout
    nlog = 0;
    tout_cnt = 0;
    push0(1'b0, 8'h9A);
    wait_log(1, "edge_first");
    t0 = en_cyc;
    for (int i = 0; i < 11; i++) tick();
    push0(1'b1, 8'h9B);
    tick();
    chk("edge_issue_en", 32'(TX_DATA_EN), 32'd1);
    chk("edge_issue_data", 32'(TX_DATA), 32'h9B);
    chk("edge_no_tout", 32'(TIMEOUT_ERR), 32'd0);
    wait_unlock("edge_unlock");
    chk("edge_tout_count", 32'(tout_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rs232c_tx_arbiter.md
RS232C_TX_ARBITER -- requirements
Module: rs232c_tx_arbiter

Interface
REQ-001 The block SHALL have parameter P_HOLD_TIMEOUT, default 16'd40000: idle cycles allowed mid-packet before the lock is forcibly released.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port RESETB, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports REQ0 and REQ1, input, 1 bit each: requester n has a byte pending.
REQ-005 The block SHALL have ports DATA0 and DATA1, input, 8 bits each: the byte offered by requester n, valid while REQn=1.
REQ-006 The block SHALL have ports LAST0 and LAST1, input, 1 bit each: the offered byte ends requester n's packet.
REQ-007 The block SHALL have ports ACK0 and ACK1, output, 1 bit each: one-cycle pulse meaning the byte was consumed; the requester updates REQ, DATA and LAST after it.
REQ-008 The block SHALL have port TX_DATA, output, 8 bits: byte to the UART transmitter.
REQ-009 The block SHALL have port TX_DATA_EN, output, 1 bit: one-cycle send command to the transmitter.
REQ-010 The block SHALL have port TX_BUSY, input, 1 bit: transmitter busy; it is high in any cycle where TX_DATA_EN=1.
REQ-011 The block SHALL have port GNT, output, 2 bits: one-hot packet owner; 2'b00 when unlocked.
REQ-012 The block SHALL have port TIMEOUT_ERR, output, 1 bit: one-cycle pulse when the hold timeout fires.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 The block SHALL implement the states IDLE, SENT and HOLD.
REQ-015 In IDLE with TX_BUSY=0 and any REQ=1, the winner SHALL be chosen by round-robin pointer rr: if both request, requester rr wins; otherwise the sole requester wins.
REQ-016 On the IDLE issue edge, the block SHALL set TX_DATA=DATAw, TX_DATA_EN=1 and ACKw=1, each for exactly one cycle.
REQ-017 On the IDLE issue edge, the block SHALL also set GNT to the one-hot winner, store last_flag=LASTw, and move to SENT.
REQ-018 In IDLE with TX_BUSY=1, the block SHALL issue nothing.
REQ-019 In SENT, the block SHALL ignore all REQ inputs and wait for TX_BUSY=0.
REQ-020 On TX_BUSY=0 in SENT with last_flag=1, the block SHALL go to IDLE, set GNT=00, and set rr to the requester other than the owner.
REQ-021 On TX_BUSY=0 in SENT with last_flag=0, the block SHALL go to HOLD and clear the hold counter.
REQ-022 In HOLD with REQ of the owner =1, the block SHALL issue the owner's byte exactly as on the IDLE issue edge and go to SENT.
REQ-023 In HOLD, REQ of the non-owner SHALL be ignored.
REQ-024 In HOLD with owner REQ=0, the 16-bit hold counter SHALL increment each cycle.
REQ-025 When the hold counter equals P_HOLD_TIMEOUT-1 and owner REQ=0, the block SHALL pulse TIMEOUT_ERR, go to IDLE, set GNT=00, and rotate rr away from the owner.
REQ-026 If owner REQ=1 in the same cycle the timeout count is reached, the issue SHALL win and no timeout occurs.
REQ-027 Latency from REQ sampled high in IDLE (with TX_BUSY=0) to TX_DATA_EN=1 SHALL be 1 cycle.
REQ-028 A packet SHALL never be interleaved with bytes from the other requester.
REQ-029 Bytes SHALL be forwarded unmodified, in order.

Reset
REQ-030 When RESETB=0, the block SHALL asynchronously force state=IDLE, TX_DATA=8'h00, TX_DATA_EN=0, ACK0=ACK1=0, GNT=00, TIMEOUT_ERR=0, rr=0, last_flag=0 and hold counter=0.
REQ-031 Reset asserted mid-packet or mid-byte SHALL abandon the packet; after release, no ACK is reissued for the abandoned byte.
REQ-032 The first issue after reset release SHALL occur no earlier than the second rising edge after release.

Verification
REQ-033 Single requester, REQ0=1, DATA0=8'h41, LAST0=1, TX_BUSY idle -> one cycle later TX_DATA=8'h41, TX_DATA_EN=1 and ACK0=1 for one cycle; GNT=01 until TX_BUSY falls, then GNT=00.
REQ-034 Both request from reset with single-byte packets 8'hA0 (req0) and 8'hB1 (req1) -> order A0 then B1; repeated, the order alternates by rr.
REQ-035 Requester 0 sends a 3-byte packet 8'h01, 8'h02, 8'h03 (LAST on 03) while REQ1 is held high -> TX order 01, 02, 03, then requester 1's byte; ACK1 never pulses before 03 completes.
REQ-036 With P_HOLD_TIMEOUT=8, requester 0 sends a non-LAST byte then drops REQ0 -> TIMEOUT_ERR pulses once 8 cycles after HOLD entry, GNT=00, and a pending REQ1 is then served.
REQ-037 RESETB pulsed low while in SENT -> all outputs take their reset values immediately; with REQ inputs low afterwards, TX_DATA_EN stays 0.
REQ-038 TX_BUSY held high externally in IDLE with REQ1=1 -> no TX_DATA_EN or ACK1 until TX_BUSY=0, then issue on the next edge.
